// File: rtl/sc_lane_sched_pkg.sv
// Shared types for the lane scheduler: FSM state codes, row shift masks, level-to-lane-period table.
// Latency: none (definitions only); backpressure: n/a.
package sc_lane_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_BANNER = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_PAUSE  = 3'd5,
        ST_OVER   = 3'd6,
        ST_WIN    = 3'd7
    } lane_state_t;

    // Rows 0 (start) and 7 (goal) are never part of either mask.
    localparam logic [7:0] LEFT_MASK  = 8'b01010100;
    localparam logic [7:0] RIGHT_MASK = 8'b00101010;

    function automatic logic [2:0] lane_period(input logic [1:0] level);
        case (level)
            2'd0:    return 3'd4;
            2'd1:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/sc_tick_prescaler.sv
// Game-tick prescaler: counts 0..TICK_DIV-1 while enabled, tick high on the terminal count.
// Latency: tick is combinational from the count; backpressure: en freezes the count, clr wins over en.
module sc_tick_prescaler #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/sc_lane_scheduler.sv
// Frog-crossing game-flow sequencer: level banner, background clear/load, per-row lane shift strobes.
// Latency: shift strobes one cycle after the game tick; backpressure: none, inputs are one-cycle active-low pulses.
module sc_lane_scheduler
    import sc_lane_sched_pkg::*;
#(
    parameter int TICK_DIV     = 12500000,
    parameter int BANNER_TICKS = 8,
    parameter int NUM_LEVELS   = 3
) (
    input  logic       SC_LANESCHED_CLOCK_50,
    input  logic       SC_LANESCHED_RESET_InLow,
    input  logic       SC_LANESCHED_start_InLow,
    input  logic       SC_LANESCHED_pause_InLow,
    input  logic       SC_LANESCHED_levelDone_InLow,
    input  logic       SC_LANESCHED_gameOver_InLow,
    output logic [1:0] SC_LANESCHED_level_OutBus,
    output logic       SC_LANESCHED_banner_Out,
    output logic       SC_LANESCHED_clear_OutLow,
    output logic       SC_LANESCHED_load_OutLow,
    output logic [7:0] SC_LANESCHED_shiftLeft_OutBus,
    output logic [7:0] SC_LANESCHED_shiftRight_OutBus,
    output logic [2:0] SC_LANESCHED_state_OutBus
);

    localparam int BW = $clog2(BANNER_TICKS + 1);
    localparam logic [BW-1:0] BANNER_LAST = BW'(BANNER_TICKS - 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          pause;
    logic          level_done;
    logic          game_over;
    lane_state_t   state;
    logic [1:0]    level;
    logic [1:0]    phase;
    logic [BW-1:0] banner_cnt;
    logic [7:0]    shift_left;
    logic [7:0]    shift_right;
    logic [2:0]    period;
    logic [2:0]    half;
    logic          tick;
    logic          run_tick;
    logic          pre_en;
    logic          pre_clr;

    assign clk        = SC_LANESCHED_CLOCK_50;
    assign rst_n      = SC_LANESCHED_RESET_InLow;
    assign start      = ~SC_LANESCHED_start_InLow;
    assign pause      = ~SC_LANESCHED_pause_InLow;
    assign level_done = ~SC_LANESCHED_levelDone_InLow;
    assign game_over  = ~SC_LANESCHED_gameOver_InLow;

    assign period   = lane_period(level);
    assign half     = period >> 1;
    assign pre_en   = (state == ST_BANNER) || (state == ST_RUN);
    // PAUSE holds the count so play resumes mid-period; every other non-counting state zeroes it.
    assign pre_clr  = !(pre_en || (state == ST_PAUSE));
    assign run_tick = tick && (state == ST_RUN);

    sc_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            level       <= 2'd0;
            phase       <= 2'd0;
            banner_cnt  <= '0;
            shift_left  <= 8'h00;
            shift_right <= 8'h00;
        end else begin
            // Computed from the current state, so a tick on an exit cycle still yields its strobe.
            shift_left  <= (run_tick && (phase == 2'd0)) ? LEFT_MASK : 8'h00;
            shift_right <= (run_tick && ({1'b0, phase} == half)) ? RIGHT_MASK : 8'h00;

            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    state      <= ST_BANNER;
                    banner_cnt <= '0;
                end
                ST_BANNER: begin
                    if (tick) begin
                        if (banner_cnt == BANNER_LAST) state <= ST_LOAD;
                        else banner_cnt <= banner_cnt + BW'(1);
                    end
                end
                ST_LOAD: begin
                    state <= ST_RUN;
                    phase <= 2'd0;
                end
                ST_RUN: begin
                    if (tick) begin
                        phase <= ({1'b0, phase} == period - 3'd1) ? 2'd0 : phase + 2'd1;
                    end
                    if (game_over) begin
                        state <= ST_OVER;
                    end else if (level_done) begin
                        if (32'(level) < 32'(NUM_LEVELS - 1)) begin
                            level <= level + 2'd1;
                            state <= ST_CLEAR;
                        end else begin
                            state <= ST_WIN;
                        end
                    end else if (pause) begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pause) state <= ST_RUN;
                end
                default: begin
                    if (start) begin
                        state <= ST_IDLE;
                        level <= 2'd0;
                    end
                end
            endcase
        end
    end

    assign SC_LANESCHED_level_OutBus      = level;
    assign SC_LANESCHED_banner_Out        = (state == ST_BANNER) || (state == ST_OVER) || (state == ST_WIN);
    assign SC_LANESCHED_clear_OutLow      = (state != ST_CLEAR);
    assign SC_LANESCHED_load_OutLow       = (state != ST_LOAD);
    assign SC_LANESCHED_shiftLeft_OutBus  = shift_left;
    assign SC_LANESCHED_shiftRight_OutBus = shift_right;
    assign SC_LANESCHED_state_OutBus      = state;

endmodule
